plic_claim_sequencer: RTL
=========================

Name: plic_claim_sequencer

Overview:
APB4 master that autonomously runs the claim/complete protocol of the PLIC on behalf of up to TARGETS interrupt targets. When a target's irq is asserted, the block reads that target's claim/complete register and hands the returned ID to the target's handler over a valid/ready handshake. It then waits for the handler's done pulse and writes the ID back to complete the interrupt. All targets share one APB master port through a round-robin arbiter. The block sits between the PLIC's APB slave port and simple handler cores that have no bus master of their own.

Parameters:
PADDR_SIZE, 32, APB address width
PDATA_SIZE, 32, APB data width (32 or 64)
SOURCES, 64, number of PLIC sources; SOURCES_BITS = $clog2(SOURCES+1)
TARGETS, 4, number of targets served
CLAIM_BASE, 32'h0020_0004, byte address of the target-0 claim/complete register
CLAIM_STRIDE, 32'h0000_1000, address step between targets
TIMEOUT_CYCLES, 1024, service timeout; used only with the optional feature

Ports:
PCLK  in  1  system clock, rising edge
PRESETn  in  1  asynchronous active-low reset
irq  in  TARGETS  interrupt requests from the PLIC
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PADDR  out  PADDR_SIZE  APB address
PWRITE  out  1  APB direction
PSTRB  out  PDATA_SIZE/8  byte strobes: all-ones on writes, zero on reads
PWDATA  out  PDATA_SIZE  write data: completed ID, zero-extended
PRDATA  in  PDATA_SIZE  read data
PREADY  in  1  APB ready
PSLVERR  in  1  APB error
id_valid  out  TARGETS  claimed ID available, per target
id  out  TARGETS*SOURCES_BITS  claimed ID; target t uses slice [t*SOURCES_BITS +: SOURCES_BITS]
id_ready  in  TARGETS  handler accepts the ID
done  in  TARGETS  one-cycle pulse: handler finished
bus_err  out  TARGETS  one-cycle pulse: PSLVERR seen on that target's transfer
timeout  out  TARGETS  one-cycle pulse: service timeout (optional feature only)

Behaviour:
- Reset: one clock, PCLK; asynchronous active-low reset, PRESETn. While PRESETn=0, all outputs are 0, all FSMs are idle, and the RR pointer = TARGETS-1, so target 0 wins first. Reset mid-transfer drops PSEL immediately; no completion is remembered after reset.
- Per-target FSM:
  - T_IDLE: irq[t]=1 -> T_CLAIM.
  - T_CLAIM: raises a read request; on transfer end -> T_DELIVER. If the read data [SOURCES_BITS-1:0]==0 (spurious), or PSLVERR=1 (also pulse bus_err[t]), go -> T_IDLE instead.
  - T_DELIVER: id_valid[t]=1 and id stable until id_ready[t]=1 -> T_SERVICE.
  - T_SERVICE: done[t]=1 -> T_COMPLETE. A done pulse in any other state is ignored.
  - T_COMPLETE: raises a write request of the latched ID; on transfer end -> T_IDLE. This happens regardless of PSLVERR, which pulses bus_err[t].
- Each target owns one ID latch. The ID is never modified between claim and complete.
- APB engine states:
  - A_IDLE -> A_SETUP when any target requests. A grant is issued on this transition.
  - A_SETUP (PSEL=1, PENABLE=0) -> A_ACCESS.
  - A_ACCESS (PSEL=1, PENABLE=1) holds until PREADY=1 -> A_IDLE.
  - Minimum 3 cycles per transfer. PADDR, PWRITE and PWDATA are constant from SETUP through ACCESS.
- PADDR = CLAIM_BASE + t*CLAIM_STRIDE, truncated to PADDR_SIZE. PRDATA is sampled only when PENABLE & PREADY.
- Arbitration:
  - Round-robin among targets in T_CLAIM/T_COMPLETE: the first requester after the pointer, searching upward with wrap-around, is granted.
  - The pointer updates to the granted index on grant.
  - A request withdrawn is impossible: requests persist until served.
- Latency with no contention and PREADY=1: irq rises before edge N -> T_CLAIM after N -> PSEL=1 after N+1 -> id_valid=1 after N+3.
- irq deasserting after T_CLAIM is entered does not cancel the claim. The read returns 0 and is handled as spurious.
- A target's irq is ignored from T_CLAIM until T_IDLE is re-entered. After completion, a still-high irq starts a new claim.

Optional Feature:
PLIC_SEQ_TIMEOUT_EN
- Defined: a per-target counter runs in T_SERVICE and clears on entry. When it reaches TIMEOUT_CYCLES-1 without done, it pulses timeout[t] and the FSM -> T_COMPLETE, auto-completing the interrupt. If done arrives in the same cycle as the timeout, done wins and no timeout pulse is generated.
- Undefined: no counters exist, timeout is tied to 0, and T_SERVICE waits for done indefinitely.

Test Plan:
- Single interrupt: irq[1]=1, PRDATA=7, id_ready=1, done pulsed 5 cycles later, expected results:
  - read at 0x0020_1004, then id_valid[1] with id=7;
  - write 7 to 0x0020_1004 with PSTRB=4'hF;
  - 2 APB transfers total.
- Spurious: irq[0] pulsed, PRDATA=0 -> no id_valid, no write; FSM idle.
- Contention: irq=4'hF simultaneously -> claims granted in order 0,1,2,3. The completes of 0 and 2, requested together with pointer=3, are granted 0 then 2.
- Wait states: PREADY low 4 cycles during claim -> PSEL/PENABLE/PADDR stable; PRDATA is taken only at the PREADY cycle.
- PSLVERR on the claim of target 2 -> bus_err[2] pulses once; target 2 returns to T_IDLE and no complete is issued.
- With PLIC_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, done withheld -> timeout[0] pulses 16 cycles after id_ready, followed by a complete write of the latched ID. Asserting PRESETn=0 in A_ACCESS drops PSEL the same cycle.

Source files
------------

// File: rtl/plic_claim_sequencer.sv
// plic_claim_sequencer
// APB4 master that runs the PLIC claim/complete handshake for up to TARGETS
// interrupt targets. Each target has its own small FSM. The FSM claims an ID
// when the target's irq rises and hands the ID to the handler. After the
// handler's done pulse it writes the ID back. All targets share one APB port
// through a round-robin arbiter.
//
// Optional build macro: PLIC_SEQ_TIMEOUT_EN
//   Defined   -> each target has a service watchdog. When it expires, the
//                block pulses timeout[t] and auto-completes the interrupt.
//   Undefined -> no watchdog, and timeout is tied to zero.
module plic_claim_sequencer #(
    parameter int          PADDR_SIZE     = 32,
    parameter int          PDATA_SIZE     = 32,
    parameter int          SOURCES        = 64,
    parameter int          TARGETS        = 4,
    parameter logic [31:0] CLAIM_BASE     = 32'h0020_0004,
    parameter logic [31:0] CLAIM_STRIDE   = 32'h0000_1000,
    parameter int          TIMEOUT_CYCLES = 1024,
    localparam int         SOURCES_BITS   = $clog2(SOURCES + 1)
) (
    input  logic                            PCLK,
    input  logic                            PRESETn,
    input  logic [TARGETS-1:0]              irq,
    output logic                            PSEL,
    output logic                            PENABLE,
    output logic [PADDR_SIZE-1:0]           PADDR,
    output logic                            PWRITE,
    output logic [PDATA_SIZE/8-1:0]         PSTRB,
    output logic [PDATA_SIZE-1:0]           PWDATA,
    input  logic [PDATA_SIZE-1:0]           PRDATA,
    input  logic                            PREADY,
    input  logic                            PSLVERR,
    output logic [TARGETS-1:0]              id_valid,
    output logic [TARGETS*SOURCES_BITS-1:0] id,
    input  logic [TARGETS-1:0]              id_ready,
    input  logic [TARGETS-1:0]              done,
    output logic [TARGETS-1:0]              bus_err,
    output logic [TARGETS-1:0]              timeout
);

    localparam int SB = SOURCES_BITS;
    localparam int TW = (TARGETS > 1) ? $clog2(TARGETS) : 1;

    typedef enum logic [2:0] {
        T_IDLE,
        T_CLAIM,
        T_DELIVER,
        T_SERVICE,
        T_COMPLETE
    } t_state_e;

    typedef enum logic [1:0] {
        A_IDLE,
        A_SETUP,
        A_ACCESS
    } a_state_e;

    // Shared APB engine state
    a_state_e              a_state_reg, a_state_next;
    logic [TW-1:0]         gnt_reg;
    logic [TW-1:0]         rr_ptr_reg;
    logic [PADDR_SIZE-1:0] paddr_reg;
    logic                  pwrite_reg;
    logic [PDATA_SIZE-1:0] pwdata_reg;

    // Arbitration and per-target views used by the engine
    logic [TARGETS-1:0]    req;
    logic [TARGETS-1:0]    req_wr;
    logic [SB-1:0]         id_arr   [TARGETS];
    logic [PADDR_SIZE-1:0] addr_tab [TARGETS];
    logic [TW-1:0]         arb_idx;
    logic [TW-1:0]         cand_idx;
    logic                  arb_found;
    logic                  grant;
    logic                  xfer_end;

    // Only the low SB bits of PRDATA carry the claimed ID.
    logic unused_prdata;
    assign unused_prdata = ^PRDATA;

    // Round-robin search: the first requester above the pointer wins, with
    // wrap-around. The pointer's own slot has the lowest priority.
    always_comb begin
        arb_idx   = rr_ptr_reg;
        arb_found = 1'b0;
        cand_idx  = rr_ptr_reg;
        for (int i = TARGETS; i >= 1; i--) begin
            cand_idx = TW'((int'(rr_ptr_reg) + i) % TARGETS);
            if (req[cand_idx]) begin
                arb_idx   = cand_idx;
                arb_found = 1'b1;
            end
        end
    end

    assign grant    = (a_state_reg == A_IDLE) && arb_found;
    assign xfer_end = (a_state_reg == A_ACCESS) && PREADY;

    // APB engine next-state: IDLE -> SETUP on grant, SETUP -> ACCESS, then
    // ACCESS waits for PREADY.
    always_comb begin
        a_state_next = a_state_reg;
        unique case (a_state_reg)
            A_IDLE:   if (grant) a_state_next = A_SETUP;
            A_SETUP:  a_state_next = A_ACCESS;
            A_ACCESS: if (PREADY) a_state_next = A_IDLE;
            default:  a_state_next = A_IDLE;
        endcase
    end

    // APB engine registers. Address, direction and data are captured at
    // grant time, so they stay frozen through SETUP and ACCESS.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            a_state_reg <= A_IDLE;
            gnt_reg     <= '0;
            rr_ptr_reg  <= TW'(TARGETS - 1);
            paddr_reg   <= '0;
            pwrite_reg  <= 1'b0;
            pwdata_reg  <= '0;
        end else begin
            a_state_reg <= a_state_next;
            if (grant) begin
                gnt_reg    <= arb_idx;
                rr_ptr_reg <= arb_idx;
                paddr_reg  <= addr_tab[arb_idx];
                pwrite_reg <= req_wr[arb_idx];
                pwdata_reg <= req_wr[arb_idx] ? PDATA_SIZE'(id_arr[arb_idx]) : '0;
            end
        end
    end

    // PSEL comes straight from the state register, so an asynchronous reset
    // drops it immediately. Outputs are zero whenever the bus is idle.
    assign PSEL    = (a_state_reg != A_IDLE);
    assign PENABLE = (a_state_reg == A_ACCESS);
    assign PADDR   = PSEL ? paddr_reg : '0;
    assign PWRITE  = PSEL & pwrite_reg;
    assign PSTRB   = (PSEL & pwrite_reg) ? '1 : '0;
    assign PWDATA  = PSEL ? pwdata_reg : '0;

    for (genvar gi = 0; gi < TARGETS; gi++) begin : g_tgt
        t_state_e      state_reg, state_next;
        logic [SB-1:0] id_reg;
        logic          berr_reg, berr_next;
        logic          load_id;
        logic          mine_end;

        assign mine_end     = xfer_end && (gnt_reg == TW'(gi));
        assign addr_tab[gi] = PADDR_SIZE'(CLAIM_BASE)
                            + PADDR_SIZE'(CLAIM_STRIDE) * PADDR_SIZE'(gi);

`ifdef PLIC_SEQ_TIMEOUT_EN
        localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
        logic [CW-1:0] cnt_reg;
        logic          tmo_hit;
        logic          tout_reg, tout_next;

        assign tmo_hit = (state_reg == T_SERVICE) && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

        // Service watchdog. It is held at zero outside T_SERVICE, so it
        // always starts from zero when T_SERVICE is entered.
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                cnt_reg  <= '0;
                tout_reg <= 1'b0;
            end else begin
                tout_reg <= tout_next;
                if (state_reg != T_SERVICE) begin
                    cnt_reg <= '0;
                end else if (!tmo_hit) begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end
        end

        assign timeout[gi] = tout_reg;
`else
        assign timeout[gi] = 1'b0;
`endif

        // Per-target claim/complete sequencing. A done pulse outside
        // T_SERVICE is ignored. irq is only looked at in T_IDLE.
        always_comb begin
            state_next = state_reg;
            berr_next  = 1'b0;
            load_id    = 1'b0;
`ifdef PLIC_SEQ_TIMEOUT_EN
            tout_next  = 1'b0;
`endif
            unique case (state_reg)
                T_IDLE: begin
                    if (irq[gi]) state_next = T_CLAIM;
                end
                T_CLAIM: begin
                    if (mine_end) begin
                        if (PSLVERR) begin
                            berr_next  = 1'b1;
                            state_next = T_IDLE;
                        end else if (PRDATA[SB-1:0] == '0) begin
                            state_next = T_IDLE;
                        end else begin
                            load_id    = 1'b1;
                            state_next = T_DELIVER;
                        end
                    end
                end
                T_DELIVER: begin
                    if (id_ready[gi]) state_next = T_SERVICE;
                end
                T_SERVICE: begin
                    if (done[gi]) begin
                        state_next = T_COMPLETE;
`ifdef PLIC_SEQ_TIMEOUT_EN
                    end else if (tmo_hit) begin
                        tout_next  = 1'b1;
                        state_next = T_COMPLETE;
`endif
                    end
                end
                T_COMPLETE: begin
                    // The complete write finishes even on PSLVERR; the error
                    // is only reported.
                    if (mine_end) begin
                        berr_next  = PSLVERR;
                        state_next = T_IDLE;
                    end
                end
                default: state_next = T_IDLE;
            endcase
        end

        // Per-target state, ID latch and error pulse register
        always_ff @(posedge PCLK or negedge PRESETn) begin
            if (!PRESETn) begin
                state_reg <= T_IDLE;
                id_reg    <= '0;
                berr_reg  <= 1'b0;
            end else begin
                state_reg <= state_next;
                berr_reg  <= berr_next;
                if (load_id) id_reg <= PRDATA[SB-1:0];
            end
        end

        assign req[gi]              = (state_reg == T_CLAIM) || (state_reg == T_COMPLETE);
        assign req_wr[gi]           = (state_reg == T_COMPLETE);
        assign id_arr[gi]           = id_reg;
        assign id_valid[gi]         = (state_reg == T_DELIVER);
        assign id[gi*SB +: SB]      = id_reg;
        assign bus_err[gi]          = berr_reg;
    end

endmodule
